// File: rtl/wrr_arb_pkg.sv
// Shared definitions for the weighted round-robin arbiter: FSM state encoding
// and the ceiling-log2 helper used to size index ports.
package wrr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Minimum number of bits needed to hold an index in the range 0..n-1
    // (never less than one).
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// rr_pick: combinational wrap-around first-set search. Scans request upward
// from base_ptr, wrapping at WIDTH-1, skipping any channel set in exclude.
module rr_pick
    import wrr_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]        request,
    input  logic [clog2(WIDTH)-1:0] base_ptr,
    input  logic [WIDTH-1:0]        exclude,
    output logic [WIDTH-1:0]        onehot,
    output logic [clog2(WIDTH)-1:0] index,
    output logic                    found
);

    localparam int IDX_W = clog2(WIDTH);

    logic [WIDTH-1:0] eligible;

    assign eligible = request & ~exclude;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned; otherwise synthesis infers a latch.
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((int'(base_ptr) + i) % WIDTH);
            if (!found && eligible[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                index        = cand;
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: one registered one-hot grant held for up to
// weight acks. Optional WRR_ARBITER_LOCK_EN adds a lock input that blocks ack.
module wrr_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int WEIGHT_W = 3
) (
    input  logic                      clk,
    input  logic                      resetb,
    input  logic                      ack,
`ifdef WRR_ARBITER_LOCK_EN
    input  logic                      lock,
`endif
    input  logic [WIDTH-1:0]          request,
    input  logic [WIDTH*WEIGHT_W-1:0] weight,
    output logic [WIDTH-1:0]          grant,
    output logic [clog2(WIDTH)-1:0]   grant_idx,
    output logic                      grant_valid
);

    localparam int IDX_W = clog2(WIDTH);

    state_t              state;
    state_t              state_next;
    logic [WIDTH-1:0]    grant_next;
    logic [IDX_W-1:0]    idx_next;
    logic                valid_next;
    logic [WEIGHT_W-1:0] credit;
    logic [WEIGHT_W-1:0] credit_next;
    logic [IDX_W-1:0]    base_ptr;
    logic [IDX_W-1:0]    base_next;

    logic [IDX_W-1:0]    next_ptr;
    logic [IDX_W-1:0]    pick_base;
    logic [WIDTH-1:0]    exclude;
    logic [WIDTH-1:0]    pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_found;
    logic [WEIGHT_W-1:0] pick_weight;
    logic [WEIGHT_W-1:0] pick_credit;
    logic                held;
    logic                ack_eff;
    logic                release_now;

`ifdef WRR_ARBITER_LOCK_EN
    assign ack_eff = ack & grant_valid & ~lock;
`else
    assign ack_eff = ack & grant_valid;
`endif

    assign held        = request[grant_idx];
    assign release_now = (state == BUSY) && (!held || (ack_eff && credit == WEIGHT_W'(1)));
    assign next_ptr    = (grant_idx == IDX_W'(WIDTH - 1)) ? '0 : grant_idx + IDX_W'(1);

    // On release the search restarts just past the holder; the holder is only
    // eligible again when nobody else is asking.
    assign pick_base = (state == BUSY) ? next_ptr : base_ptr;
    assign exclude   = ((state == BUSY) && ((request & ~grant) != '0)) ? grant : '0;

    rr_pick #(
        .WIDTH (WIDTH)
    ) u_pick (
        .request  (request),
        .base_ptr (pick_base),
        .exclude  (exclude),
        .onehot   (pick_onehot),
        .index    (pick_idx),
        .found    (pick_found)
    );

    always_comb begin
        pick_weight = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_weight = weight[i*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

    assign pick_credit = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;

    always_comb begin
        state_next  = state;
        grant_next  = grant;
        idx_next    = grant_idx;
        valid_next  = grant_valid;
        credit_next = credit;
        base_next   = base_ptr;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next  = BUSY;
                    grant_next  = pick_onehot;
                    idx_next    = pick_idx;
                    valid_next  = 1'b1;
                    credit_next = pick_credit;
                end
            end
            BUSY: begin
                if (release_now) begin
                    base_next = next_ptr;
                    if (pick_found) begin
                        grant_next  = pick_onehot;
                        idx_next    = pick_idx;
                        valid_next  = 1'b1;
                        credit_next = pick_credit;
                    end else begin
                        state_next  = IDLE;
                        grant_next  = '0;
                        idx_next    = '0;
                        valid_next  = 1'b0;
                        credit_next = '0;
                    end
                end else if (ack_eff) begin
                    credit_next = credit - WEIGHT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments only in clocked blocks, so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (resetb) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            credit      <= '0;
            base_ptr    <= '0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            grant_idx   <= idx_next;
            grant_valid <= valid_next;
            credit      <= credit_next;
            base_ptr    <= base_next;
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural arbitration model.
module tb_wrr_arbiter;

    localparam int W  = 4;
    localparam int WW = 3;

    logic          clk = 1'b0;
    logic          resetb;
    logic          ack;
    logic          lock;
    logic [W-1:0]  request;
    logic [W*WW-1:0] weight;
    logic [W-1:0]  grant;
    logic [1:0]    grant_idx;
    logic          grant_valid;

    int wts[W];
    int checks   = 0;
    int failures = 0;

    // Model: holder index (-1 when idle), remaining credit, search pointer.
    int m_idx    = -1;
    int m_credit = 0;
    int m_base   = 0;

    always #5 clk = ~clk;

    wrr_arbiter #(
        .WIDTH    (W),
        .WEIGHT_W (WW)
    ) dut (
        .clk         (clk),
        .resetb      (resetb),
        .ack         (ack),
`ifdef WRR_ARBITER_LOCK_EN
        .lock        (lock),
`endif
        .request     (request),
        .weight      (weight),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    task automatic set_weights();
        for (int i = 0; i < W; i++) begin
            weight[i*WW +: WW] = WW'(wts[i]);
        end
    endtask

    function automatic int first_req(input int start, input int self_idx);
        for (int k = 0; k < W; k++) begin
            int c;
            c = (start + k) % W;
            if (request[c] && c != self_idx) return c;
        end
        if (self_idx >= 0 && request[self_idx]) return self_idx;
        return -1;
    endfunction

    function automatic void give(input int pick);
        m_idx    = pick;
        m_credit = (pick < 0) ? 0 : ((wts[pick] == 0) ? 1 : wts[pick]);
    endfunction

    function automatic void model_update();
        bit held;
        bit acked;
        if (resetb) begin
            m_idx = -1; m_credit = 0; m_base = 0;
        end else if (m_idx < 0) begin
            give(first_req(m_base, -1));
        end else begin
            held  = request[m_idx];
            acked = ack && !lock;
            if (held && acked && m_credit > 1) begin
                m_credit--;
            end else if (!held || acked) begin
                m_base = (m_idx + 1) % W;
                give(first_req(m_base, m_idx));
            end
        end
    endfunction

    function automatic logic [W-1:0] model_grant();
        return (m_idx < 0) ? '0 : (W'(1) << m_idx);
    endfunction

    // Inputs change at the falling edge; outputs are read one falling edge later.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetb = 1'b1; request = '0; ack = 1'b0; lock = 1'b0;
        for (int i = 0; i < W; i++) wts[i] = 1;
        set_weights();
        step();
        resetb = 1'b0;
    endtask

    task automatic test_reset();
        resetb = 1'b1; request = 4'b1111; ack = 1'b1;
        step();
        step();
        checks++;
        if (grant !== 4'b0000) begin
            failures++; $display("FAIL reset_grant: got=%b want=%b", grant, 4'b0000);
        end
        checks++;
        if (grant_idx !== 2'd0) begin
            failures++; $display("FAIL reset_idx: got=%0d want=0", grant_idx);
        end
        checks++;
        if (grant_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got=%b want=0", grant_valid);
        end
        resetb = 1'b0;
    endtask

    task automatic test_rr_sweep();
        logic [W-1:0] exp_g[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int           exp_i[5] = '{0, 1, 2, 3, 0};
        do_reset();
        request = 4'b1111; ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (grant !== exp_g[i] || grant_valid !== 1'b1) begin
                failures++;
                $display("FAIL rr_sweep[%0d]: got=%b valid=%b want=%b valid=1", i, grant, grant_valid, exp_g[i]);
            end
            checks++;
            if (grant_idx !== 2'(exp_i[i])) begin
                failures++; $display("FAIL rr_sweep_idx[%0d]: got=%0d want=%0d", i, grant_idx, exp_i[i]);
            end
        end
    endtask

    task automatic test_weight();
        logic [W-1:0] exp_g[7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
        do_reset();
        wts[2] = 3;
        set_weights();
        request = 4'b0100; ack = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) request = 4'b0101;
            step();
            checks++;
            if (grant !== exp_g[i]) begin
                failures++; $display("FAIL weight[%0d]: got=%b want=%b", i, grant, exp_g[i]);
            end
        end
    endtask

    task automatic test_drop();
        logic [W-1:0] req_s[5] = '{4'b0010, 4'b0010, 4'b1010, 4'b1000, 4'b1110};
        logic         ack_s[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] exp_g[5] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            request = req_s[i]; ack = ack_s[i];
            step();
            checks++;
            if (grant !== exp_g[i]) begin
                failures++; $display("FAIL drop[%0d]: got=%b want=%b", i, grant, exp_g[i]);
            end
        end
    endtask

    task automatic test_idle_ack();
        do_reset();
        request = '0; ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
                failures++; $display("FAIL idle_ack[%0d]: got=%b valid=%b want=0000 valid=0", i, grant, grant_valid);
            end
        end
        request = 4'b1111; ack = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0001) begin
            failures++; $display("FAIL idle_ack_base: got=%b want=%b", grant, 4'b0001);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wts[2] = 3;
        set_weights();
        request = 4'b0100; ack = 1'b0;
        step();
        ack = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0100) begin
            failures++; $display("FAIL reset_mid_pre: got=%b want=%b", grant, 4'b0100);
        end
        resetb = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid: got=%b valid=%b idx=%0d want=0000 valid=0 idx=0", grant, grant_valid, grant_idx);
        end
        resetb = 1'b0; request = 4'b0110; ack = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0010) begin
            failures++; $display("FAIL reset_mid_post: got=%b want=%b", grant, 4'b0010);
        end
    endtask

`ifdef WRR_ARBITER_LOCK_EN
    task automatic test_lock();
        do_reset();
        request = 4'b0011; ack = 1'b1; lock = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (grant !== 4'b0001) begin
                failures++; $display("FAIL lock_hold[%0d]: got=%b want=%b", i, grant, 4'b0001);
            end
        end
        lock = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0010) begin
            failures++; $display("FAIL lock_release: got=%b want=%b", grant, 4'b0010);
        end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] eg;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            request = W'($urandom);
            ack     = ($urandom_range(0, 9) < 6);
            resetb  = ($urandom_range(0, 99) == 0);
`ifdef WRR_ARBITER_LOCK_EN
            lock    = ($urandom_range(0, 9) < 3);
`endif
            for (int i = 0; i < W; i++) wts[i] = $urandom_range(0, 7);
            set_weights();
            step();
            eg = model_grant();
            checks++;
            if (grant !== eg || grant_valid !== (m_idx >= 0)) begin
                failures++;
                $display("FAIL random[%0d]: got=%b valid=%b want=%b valid=%0d", n, grant, grant_valid, eg, m_idx >= 0);
            end
            checks++;
            if (grant_idx !== 2'((m_idx < 0) ? 0 : m_idx)) begin
                failures++; $display("FAIL random_idx[%0d]: got=%0d want=%0d", n, grant_idx, (m_idx < 0) ? 0 : m_idx);
            end
            checks++;
            if ($countones(grant) > 1) begin
                failures++; $display("FAIL random_onehot[%0d]: got=%b want=at most one bit", n, grant);
            end
        end
        resetb = 1'b0;
    endtask

    initial begin
        resetb = 1'b1; ack = 1'b0; lock = 1'b0; request = '0;
        for (int i = 0; i < W; i++) wts[i] = 1;
        set_weights();
        test_reset();
        test_rr_sweep();
        test_weight();
        test_drop();
        test_idle_ack();
        test_reset_mid();
`ifdef WRR_ARBITER_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wrr_arbiter.md
WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, number of requesting channels (2..32).
REQ-002 Parameter WEIGHT_W, default 3, bit width of each channel weight.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetb  input  1  synchronous, active-high reset.
REQ-005 ack  input  1  the granted channel's transaction completes this cycle.
REQ-006 request  input  WIDTH  per-channel request level.
REQ-007 weight  input  WIDTH*WEIGHT_W  channel i weight in bits [i*WEIGHT_W +: WEIGHT_W]; sampled only when a new grant is issued.
REQ-008 grant  output  WIDTH  registered one-hot grant; all zero when idle.
REQ-009 grant_idx  output  clog2(WIDTH)  binary index of the granted channel; 0 when idle.
REQ-010 grant_valid  output  1  high exactly when grant is non-zero.

Function
REQ-011 The FSM SHALL have two states: IDLE (no grant) and BUSY (one grant held).
REQ-012 IDLE to BUSY: any request bit high; the winner SHALL be the first set request at or after base_ptr, searching upward with wrap-around; grant is visible the next cycle (1-cycle latency).
REQ-013 On grant issue, credit SHALL load max(weight[winner], 1); weight 0 is treated as 1.
REQ-014 In BUSY, grant SHALL hold until ack, or until request[grant_idx] drops.
REQ-015 Ack with credit > 1 and request[grant_idx] still high: grant unchanged, credit decrements, base_ptr unchanged.
REQ-016 Ack with credit == 1, or request[grant_idx] dropped: base_ptr SHALL become grant_idx+1 mod WIDTH; the next winner is chosen in the same cycle from that pointer, excluding the current channel unless it is the only requester; the new grant appears the next cycle with no idle bubble; if no requests remain, go to IDLE.
REQ-017 Ack while grant_valid is low SHALL be ignored.
REQ-018 Request changes on non-granted channels SHALL NOT affect an active grant.
REQ-019 Ack and the drop of request[grant_idx] in the same cycle SHALL count as one release (REQ-016 applies).
REQ-020 At most one grant bit SHALL be high in any cycle; the grant output SHALL be driven directly from flops.

Reset
REQ-021 resetb high at a clock edge: state IDLE, grant 0, grant_idx 0, grant_valid 0, credit 0, base_ptr 0, lock state cleared.
REQ-022 Reset asserted mid-grant SHALL drop the grant in the following cycle regardless of ack or request.

Configuration
REQ-023 Macro WRR_ARBITER_LOCK_EN: when defined, an extra input port lock (1 bit, after ack) is added; while lock is high and grant_valid is high, ack SHALL NOT decrement credit or release the grant; only a dropped request or reset releases it.
REQ-024 Without WRR_ARBITER_LOCK_EN, the lock port SHALL NOT exist and behaviour is exactly REQ-011..REQ-020.

Structure
REQ-025 Shared package wrr_arb_pkg SHALL hold the FSM state encoding (IDLE=0, BUSY=1) and the clog2 helper constant function.
REQ-026 One combinational sub-module, rr_pick, SHALL implement the wrap-around first-set search (inputs request, base_ptr, exclude mask; outputs one-hot, index, found); it is instantiated once.

Verification
REQ-027 Reset, then request=4'b1111 with all weights 1 and ack every cycle -> grants 0001,0010,0100,1000,0001 on consecutive cycles, with no bubbles.
REQ-028 weight[2]=3, other weights 1, request=4'b0100 held, ack every cycle -> grant 0100 for 3 acks, then re-granted to 0100 (sole requester) with credit reloaded to 3.
REQ-029 request=4'b1010, grant 0010, base_ptr 2; request[1] drops with no ack -> next grant 1000; afterwards base_ptr is 0 (wraps past index 3 once channel 3 releases).
REQ-030 Ack pulsed while idle with request=0 -> grant stays 0 and base_ptr stays 0.
REQ-031 resetb asserted while grant=0100 and credit=2 -> the following cycle grant=0, grant_valid=0; after deassertion, request=4'b0110 -> grant 0010.
REQ-032 With WRR_ARBITER_LOCK_EN defined: lock=1 and ack=1 for 5 cycles on grant 0001 (weight 1) -> grant remains 0001; lock drops with ack high -> next cycle grant moves to the next requester.
